// File: rtl/nibble_word_packer.sv
// Packs a stream of NIB_W-bit nibbles into OUT_W-bit words with a runtime word length,
// zero/sign extension of the unused upper bits, early flush of partial words and a held output slot.
module nibble_word_packer #(
    parameter int NIB_W    = 4,
    parameter int OUT_W    = 32,
    parameter int MAX_NIBS = OUT_W / NIB_W,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [NIB_W-1:0] in_data,
    output logic             in_ready,
    input  logic [CNT_W-1:0] count_cfg,
    input  logic             sign_ext,
    input  logic             flush,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count
);

    logic [OUT_W-1:0] asm_reg;
    logic [OUT_W-1:0] asm_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] cfg_map;
    logic [CNT_W-1:0] cur_target;
    logic             sext_l;
    logic             cur_sext;
    logic             flush_pend;
    logic             slot_free;
    logic             will_complete;
    logic             accept;
    logic             complete;
    logic             emit_flush;
    logic             set_flush;

    // Fill every nibble slot at or above index n with zeros or with the MSB of nibble n-1.
    function automatic logic [OUT_W-1:0] extend(input logic [OUT_W-1:0] w,
                                                input logic [CNT_W-1:0] n,
                                                input logic s);
        logic             fill;
        logic [OUT_W-1:0] r;
        fill = 1'b0;
        r    = w;
        for (int unsigned i = 0; i < MAX_NIBS; i++) begin
            if (CNT_W'(i + 1) == n)
                fill = s & w[i*NIB_W + NIB_W - 1];
        end
        for (int unsigned i = 0; i < MAX_NIBS; i++) begin
            if (CNT_W'(i) >= n)
                r[i*NIB_W +: NIB_W] = {NIB_W{fill}};
        end
        return r;
    endfunction

    always_comb begin
        cfg_map = (count_cfg == '0 || count_cfg > CNT_W'(MAX_NIBS)) ? CNT_W'(MAX_NIBS) : count_cfg;
        // The first nibble of a word uses the live config; later nibbles use the latched copy.
        cur_target    = (cnt == '0) ? cfg_map  : target;
        cur_sext      = (cnt == '0) ? sign_ext : sext_l;
        slot_free     = !out_valid || out_ready;
        will_complete = (cnt + CNT_W'(1)) == cur_target;
        in_ready      = !flush_pend && !(will_complete && !slot_free);
        accept        = in_valid && in_ready;
        complete      = accept && will_complete;
        emit_flush    = flush_pend && slot_free;
        set_flush     = flush && !flush_pend && !complete && (cnt != '0 || accept);

        asm_next = asm_reg;
        for (int unsigned i = 0; i < MAX_NIBS; i++) begin
            if (CNT_W'(i) == cnt)
                asm_next[i*NIB_W +: NIB_W] = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_reg    <= '0;
            cnt        <= '0;
            target     <= '0;
            sext_l     <= 1'b0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_count  <= '0;
        end else begin
            if (accept && cnt == '0) begin
                target <= cfg_map;
                sext_l <= sign_ext;
            end

            if (complete) begin
                asm_reg <= '0;
                cnt     <= '0;
            end else if (accept) begin
                asm_reg <= asm_next;
                cnt     <= cnt + CNT_W'(1);
            end else if (emit_flush) begin
                asm_reg <= '0;
                cnt     <= '0;
            end

            if (emit_flush)
                flush_pend <= 1'b0;
            else if (set_flush)
                flush_pend <= 1'b1;

            // A load in the same cycle as a consume keeps out_valid high for back-to-back words.
            if (complete) begin
                out_valid <= 1'b1;
                out_data  <= extend(asm_next, cur_target, cur_sext);
                out_count <= cur_target;
            end else if (emit_flush) begin
                out_valid <= 1'b1;
                out_data  <= extend(asm_reg, cnt, sext_l);
                out_count <= cnt;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nibble_word_packer.sv
// Directed and randomized checks of nibble_word_packer against a queue-based word model.
module tb_nibble_word_packer;

    localparam int NIB_W    = 4;
    localparam int OUT_W    = 32;
    localparam int CNT_W    = 4;
    localparam int MAX_NIBS = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [NIB_W-1:0] in_data = '0;
    logic             in_ready;
    logic [CNT_W-1:0] count_cfg = '0;
    logic             sign_ext = 1'b0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] out_count;

    int vectors = 0;
    int errors  = 0;

    // Reference state: nibbles of the word under construction, its target/sign mode,
    // pending flush, and the expected contents of the output slot.
    int     nq[$];
    int     m_tgt  = 0;
    bit     m_sext = 1'b0;
    bit     m_pend = 1'b0;
    bit     m_ov   = 1'b0;
    longint m_data = 0;
    int     m_cnt  = 0;

    always #5 clk = ~clk;

    nibble_word_packer #(
        .NIB_W(NIB_W),
        .OUT_W(OUT_W),
        .MAX_NIBS(MAX_NIBS),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .count_cfg(count_cfg),
        .sign_ext(sign_ext),
        .flush(flush),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .out_count(out_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word value as an integer: sum of nibble*16^k, plus 2^32-2^(4n) when sign-extending a negative top nibble.
    function automatic longint pack(input int n, input bit s);
        longint w = 0;
        for (int k = 0; k < n; k++)
            w += longint'(nq[k]) * (longint'(1) << (NIB_W * k));
        if (s && nq[n-1] >= 8)
            w += (longint'(1) << OUT_W) - (longint'(1) << (NIB_W * n));
        return w;
    endfunction

    task automatic load(input int n);
        m_data = pack(n, m_sext);
        m_cnt  = n;
        m_ov   = 1'b1;
        nq.delete();
    endtask

    task automatic model_reset();
        nq.delete();
        m_pend = 1'b0;
        m_ov   = 1'b0;
        m_data = 0;
        m_cnt  = 0;
    endtask

    // One clock: check outputs and in_ready against the model, advance the model, step to edge+1.
    task automatic tick();
        int cfgm;
        int tgt;
        bit slot_free;
        bit exp_rdy;
        bit acc;
        bit done;
        #1;
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("out_data", out_data, m_data);
            chk("out_count", out_count, m_cnt);
        end
        cfgm      = (count_cfg == 0 || count_cfg > MAX_NIBS) ? MAX_NIBS : int'(count_cfg);
        tgt       = (nq.size() == 0) ? cfgm : m_tgt;
        slot_free = !m_ov || out_ready;
        exp_rdy   = !m_pend && !((nq.size() + 1 == tgt) && !slot_free);
        chk("in_ready", in_ready, exp_rdy);
        acc  = in_valid && exp_rdy;
        done = 1'b0;
        if (m_ov && out_ready) m_ov = 1'b0;
        if (acc) begin
            if (nq.size() == 0) begin
                m_tgt  = cfgm;
                m_sext = sign_ext;
            end
            nq.push_back(int'(in_data));
            if (nq.size() == m_tgt) begin
                load(m_tgt);
                done = 1'b1;
            end
        end
        if (!done) begin
            if (m_pend && slot_free) begin
                load(nq.size());
                m_pend = 1'b0;
            end else if (flush && nq.size() > 0 && !m_pend) begin
                m_pend = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NIB_W-1:0] nib);
        in_valid = 1'b1;
        in_data  = nib;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_count", out_count, 4'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // Legacy two-nibble packing
        out_ready = 1'b1;
        count_cfg = 4'd2;
        sign_ext  = 1'b0;
        send(4'h5);
        send(4'hA);
        chk("legacy_valid", out_valid, 1'b1);
        chk("legacy_data", out_data, 32'h000000A5);
        chk("legacy_count", out_count, 4'd2);
        tick();

        // Full word; config change mid-word must not apply
        count_cfg = 4'd0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) count_cfg = 4'd3;
            send(NIB_W'(i));
        end
        chk("full_data", out_data, 32'h87654321);
        chk("full_count", out_count, 4'd8);

        // Sign extension
        count_cfg = 4'd3;
        sign_ext  = 1'b1;
        send(4'h1);
        send(4'h2);
        send(4'hF);
        chk("sext_neg", out_data, 32'hFFFFFF21);
        send(4'h1);
        send(4'h2);
        send(4'h7);
        chk("sext_pos", out_data, 32'h00000721);
        tick();

        // Backpressure
        count_cfg = 4'd2;
        sign_ext  = 1'b0;
        out_ready = 1'b0;
        send(4'h1);
        send(4'h2);
        send(4'h3);
        in_valid = 1'b1;
        in_data  = 4'h4;
        #1;
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_hold", out_data, 32'h00000021);
        tick();
        chk("bp_still_held", out_data, 32'h00000021);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_second", out_data, 32'h00000043);
        chk("bp_second_cnt", out_count, 4'd2);

        // Flush of a partial word
        count_cfg = 4'd8;
        send(4'hC);
        send(4'h3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        tick();
        chk("flush_valid", out_valid, 1'b1);
        chk("flush_data", out_data, 32'h0000003C);
        chk("flush_count", out_count, 4'd2);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("flush_empty", out_valid, 1'b0);

        // Asynchronous reset mid-word
        count_cfg = 4'd4;
        send(4'hA);
        send(4'hB);
        #2;
        rst_n = 1'b0;
        #1;
        chk("amid_valid", out_valid, 1'b0);
        chk("amid_data", out_data, 32'h0);
        chk("amid_count", out_count, 4'h0);
        model_reset();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) send(NIB_W'(i));
        chk("post_rst_data", out_data, 32'h00004321);
        chk("post_rst_count", out_count, 4'd4);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_data   = NIB_W'($urandom);
            count_cfg = CNT_W'($urandom);
            sign_ext  = 1'($urandom);
            out_ready = ($urandom_range(9) < 7);
            flush     = ($urandom_range(11) == 0);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
